// File: rtl/mc_main_controller.sv
// mc_main_controller
//   Main control FSM for the multicycle RV32I core. Sequences the shared ALU,
//   instruction register, PC and unified memory through fetch, decode,
//   execute and writeback. Memory accesses stall on mem_ready.
//
// Handshake: mem_req (with mem_write) is held stable while mem_ready=0; an
//   access completes in the cycle where mem_req=1 and mem_ready=1. mem_ready
//   is ignored in states that do not request memory.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   op                opcode from the instruction register
//   zero              ALU zero flag (branch qualification)
//   mem_ready         memory completes the current access this cycle
//   mem_req/mem_write memory request / write qualifier
//   adr_src           memory address select (0 PC, 1 ALUOut)
//   ir_write/pc_write load IR+OldPC / load PC
//   reg_write         register file write enable
//   alu_src_a/b       ALU operand selects
//   alu_op            ALU operation class into the ALU decoder
//   result_src        result select
//   illegal_instr     one-cycle pulse in DECODE on an unknown opcode
//   state_o           current state for debug
module mc_main_controller #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic       illegal_instr,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECUTEI = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  logic [3:0] state;
  logic [3:0] state_next;
  logic       op_known;

  assign op_known = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                    (op == OP_I) || (op == OP_JAL) || (op == OP_BEQ);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECUTER;
          OP_I:         state_next = S_EXECUTEI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default:      state_next = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_BEQ:      state_next = S_FETCH;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_FETCH;
    endcase
  end

  // Output decode. Unlisted outputs are 0 in every state; reset overrides
  // all enables so a pending write is dropped without waiting for a clock.
  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    result_src    = 2'b00;
    illegal_instr = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a     = 2'b01;
        alu_src_b     = 2'b01;
        illegal_instr = !op_known;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = zero;
      end
      S_HALT: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
      adr_src       = 1'b0;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b10;
      alu_op        = 2'b00;
      result_src    = 2'b10;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_mc_main_controller.sv
// Testbench for mc_main_controller. Two instances share stimulus: one with
// HALT_ON_ILLEGAL=0, one with HALT_ON_ILLEGAL=1. The driver walks whole
// instructions and pushes the expected per-cycle output vector of each
// instance; a monitor on the falling edge pops and compares.
module tb_mc_main_controller;

  localparam int W = 19;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;

  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_instr;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0] state_o;

  logic       h_mem_req, h_mem_write, h_adr_src, h_ir_write, h_pc_write, h_reg_write, h_illegal_instr;
  logic [1:0] h_alu_src_a, h_alu_src_b, h_alu_op, h_result_src;
  logic [3:0] h_state_o;

  mc_main_controller #(.HALT_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .illegal_instr(illegal_instr), .state_o(state_o)
  );

  mc_main_controller #(.HALT_ON_ILLEGAL(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(h_mem_req), .mem_write(h_mem_write), .adr_src(h_adr_src),
    .ir_write(h_ir_write), .pc_write(h_pc_write), .reg_write(h_reg_write),
    .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b), .alu_op(h_alu_op),
    .result_src(h_result_src), .illegal_instr(h_illegal_instr), .state_o(h_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_h_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit halted = 0;

  function automatic logic [W-1:0] rec(input logic [3:0] s, input logic mreq, input logic mwr,
                                       input logic adr, input logic irw, input logic pcw,
                                       input logic rw, input logic ill, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] aop,
                                       input logic [1:0] res);
    return {s, mreq, mwr, adr, irw, pcw, rw, ill, a, b, aop, res};
  endfunction

  logic [W-1:0] rst_r, halt_r, aluwb_r;
  initial begin
    rst_r   = rec(4'd0,  0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10);
    halt_r  = rec(4'd11, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10);
    aluwb_r = rec(4'd7,  0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // Monitor: compares one vector per instance every falling edge.
  always @(negedge clk) begin
    logic [W-1:0] got0, goth, e;
    got0 = {state_o, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
            illegal_instr, alu_src_a, alu_src_b, alu_op, result_src};
    goth = {h_state_o, h_mem_req, h_mem_write, h_adr_src, h_ir_write, h_pc_write,
            h_reg_write, h_illegal_instr, h_alu_src_a, h_alu_src_b, h_alu_op, h_result_src};
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("outputs_halt0", 32'(got0), 32'(e));
    end
    if (exp_h_q.size() > 0) begin
      e = exp_h_q.pop_front();
      chk("outputs_halt1", 32'(goth), 32'(e));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [W-1:0] e0, input logic [W-1:0] eh);
    exp_q.push_back(e0);
    exp_h_q.push_back(halted ? halt_r : eh);
    @(posedge clk);
    #1;
  endtask

  task automatic noise();
    op        = 7'($urandom);
    zero      = 1'($urandom);
    mem_ready = 1'($urandom);
  endtask

  task automatic do_reset(input int n);
    rst_n  = 1'b0;
    halted = 0;
    repeat (n) begin
      noise();
      step(rst_r, rst_r);
    end
    rst_n = 1'b1;
  endtask

  task automatic do_fetch(input int stall);
    logic [W-1:0] r;
    r = rec(4'd0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10);
    repeat (stall) begin
      noise();
      mem_ready = 1'b0;
      step(r, r);
    end
    noise();
    mem_ready = 1'b1;
    r = rec(4'd0, 1, 0, 0, 1, 1, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10);
    step(r, r);
  endtask

  task automatic mem_access(input logic [W-1:0] r, input int stall);
    repeat (stall) begin
      noise();
      mem_ready = 1'b0;
      step(r, r);
    end
    noise();
    mem_ready = 1'b1;
    step(r, r);
  endtask

  task automatic run_instr(input logic [6:0] o, input logic z, input int fstall, input int mstall);
    logic [W-1:0] r;
    bit legal;
    do_fetch(fstall);
    legal = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
            (o == 7'b0010011) || (o == 7'b1101111) || (o == 7'b1100011);
    noise();
    op = o;
    r = rec(4'd1, 0, 0, 0, 0, 0, 0, !legal, 2'b01, 2'b01, 2'b00, 2'b00);
    step(r, r);
    if (!legal) begin
      halted = 1;
      return;
    end
    case (o)
      7'b0110011, 7'b0010011: begin
        noise();
        if (o == 7'b0110011) r = rec(4'd6, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00);
        else                 r = rec(4'd8, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b00);
        step(r, r);
        noise();
        step(aluwb_r, aluwb_r);
      end
      7'b0000011, 7'b0100011: begin
        noise();
        op = o;
        r = rec(4'd2, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00);
        step(r, r);
        if (o == 7'b0000011) begin
          mem_access(rec(4'd3, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), mstall);
          noise();
          r = rec(4'd4, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01);
          step(r, r);
        end else begin
          mem_access(rec(4'd5, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), mstall);
        end
      end
      7'b1100011: begin
        noise();
        zero = z;
        r = rec(4'd10, 0, 0, 0, 0, z, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00);
        step(r, r);
      end
      default: begin
        noise();
        r = rec(4'd9, 0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00);
        step(r, r);
        noise();
        step(aluwb_r, aluwb_r);
      end
    endcase
  endtask

  // Store stalled in MEMWRITE, then reset dropped between clock edges.
  task automatic sw_with_reset();
    logic [W-1:0] r;
    do_fetch(0);
    noise();
    op = 7'b0100011;
    r = rec(4'd1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00);
    step(r, r);
    noise();
    op = 7'b0100011;
    r = rec(4'd2, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00);
    step(r, r);
    noise();
    mem_ready = 1'b0;
    r = rec(4'd5, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
    exp_q.push_back(r);
    exp_h_q.push_back(halted ? halt_r : r);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req",   32'(mem_req),   32'd0);
    chk("async_rst_mem_write", 32'(mem_write), 32'd0);
    chk("async_rst_state",     32'(state_o),   32'd0);
    chk("async_rst_state_h",   32'(h_state_o), 32'd0);
    @(posedge clk);
    #1;
    do_reset(2);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    op = '0;
    zero = 1'b0;
    mem_ready = 1'b0;
    do_reset(3);

    run_instr(7'b0110011, 1'b0, 0, 0);
    run_instr(7'b0000011, 1'b0, 0, 2);
    run_instr(7'b1100011, 1'b1, 0, 0);
    run_instr(7'b1100011, 1'b0, 0, 0);
    run_instr(7'b1101111, 1'b0, 0, 0);
    run_instr(7'b0100011, 1'b0, 1, 1);
    run_instr(7'b0010011, 1'b0, 0, 0);
    run_instr(7'b1111111, 1'b0, 0, 0);
    run_instr(7'b0110011, 1'b0, 0, 0);
    run_instr(7'b0000011, 1'b0, 1, 1);
    do_reset(1);
    sw_with_reset();

    for (int i = 0; i < 300; i++) begin
      logic [6:0] o;
      case ($urandom_range(0, 6))
        0: o = 7'b0110011;
        1: o = 7'b0010011;
        2: o = 7'b0000011;
        3: o = 7'b0100011;
        4: o = 7'b1100011;
        5: o = 7'b1101111;
        default: o = 7'($urandom);
      endcase
      if ($urandom_range(0, 24) == 0) do_reset($urandom_range(1, 2));
      if ($urandom_range(0, 39) == 0) sw_with_reset();
      run_instr(o, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || exp_h_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expected entries left, required 0", exp_q.size(), exp_h_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
